mul_arb: RTL and testbench

MUL_ARB -- requirements
Module: mul_arb

---
 rtl/mul_arb.sv | 189 ++++++++++++++++++
 tb/tb_mul_arb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arb.sv
// ============================================================================
//  Module      : mul_arb (with booth_wallace_multiplier)
//  Description : Arbitrates NREQ signed-multiply requesters onto one shared
//                radix-4 Booth / carry-save multiplier. The product lands in
//                a single output register one cycle after the grant.
//                Round-robin arbitration by default; define
//                MUL_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_wallace_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0]   a_i,
    input  logic signed [WIDTH-1:0]   b_i,
    output logic signed [2*WIDTH-1:0] p_o
);
    localparam int PW  = 2 * WIDTH;
    localparam int WE  = WIDTH + (WIDTH % 2);   // multiplier padded to even width
    localparam int NPP = WE / 2;                // radix-4 digit count

    logic signed [PW-1:0] w_ax;
    logic signed [WE-1:0] w_bs;
    logic [WE:0]          w_bx;                 // multiplier with implicit b[-1]=0
    logic [PW-1:0]        w_pp [NPP];
    logic [PW-1:0]        w_s;
    logic [PW-1:0]        w_c;
    logic [PW-1:0]        w_t;

    assign w_ax = a_i;
    assign w_bs = b_i;
    assign w_bx = {w_bs, 1'b0};

    // One Booth-recoded partial product per overlapping 3-bit group
    for (genvar j = 0; j < NPP; j++) begin : g_pp
        logic [2:0]    w_grp;
        logic          w_one;
        logic          w_two;
        logic [PW-1:0] w_mag;
        logic [PW-1:0] w_sgn;
        assign w_grp   = w_bx[2*j +: 3];
        assign w_one   = w_grp[0] ^ w_grp[1];
        assign w_two   = (w_grp == 3'b011) || (w_grp == 3'b100);
        assign w_mag   = w_one ? w_ax : (w_two ? {w_ax[PW-2:0], 1'b0} : '0);
        assign w_sgn   = w_grp[2] ? ((~w_mag) + {{(PW-1){1'b0}}, 1'b1}) : w_mag;
        assign w_pp[j] = w_sgn << (2 * j);
    end

    // Carry-save reduction of the partial products, then one final adder
    always_comb begin
        w_s = '0;
        w_c = '0;
        w_t = '0;
        for (int j = 0; j < NPP; j++) begin
            w_t = w_s ^ w_c ^ w_pp[j];
            w_c = ((w_s & w_c) | (w_s & w_pp[j]) | (w_c & w_pp[j])) << 1;
            w_s = w_t;
        end
        p_o = w_s + w_c;
    end
endmodule

module mul_arb #(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 4,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*WIDTH-1:0]      rsp_product,
    output logic [IDW-1:0]          rsp_id
);
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   rsp_product_q;
    logic [IDW-1:0]       rsp_id_q;
    logic                 w_grant_vld;
    logic [IDW-1:0]       w_grant_idx;
    logic                 w_can_accept;
    logic                 w_xfer;
    logic [WIDTH-1:0]     w_a_sel;
    logic [WIDTH-1:0]     w_b_sel;
    logic [2*WIDTH-1:0]   w_prod;

`ifdef MUL_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest valid index wins
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] ptr_q, ptr_d;

    // Round-robin: first valid requester at or above ptr, wrapping at NREQ
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            int             t;
            logic [IDW-1:0] idx;
            t = int'(ptr_q) + k;
            if (t >= NREQ) t = t - NREQ;
            idx = IDW'(t);
            if (!w_grant_vld && req_valid[idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = idx;
            end
        end
    end

    // Pointer advances past the winner only on an actual transfer
    always_comb begin
        ptr_d = ptr_q;
        if (w_xfer) begin
            ptr_d = (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    // Grant is only issued when the output register can take a new result
    assign w_can_accept = !rst && ((state_q == EMPTY) || rsp_ready);
    assign w_xfer       = w_can_accept && w_grant_vld;
    assign req_ready    = w_xfer ? ({{(NREQ-1){1'b0}}, 1'b1} << w_grant_idx) : '0;

    assign w_a_sel = req_a[w_grant_idx*WIDTH +: WIDTH];
    assign w_b_sel = req_b[w_grant_idx*WIDTH +: WIDTH];

    booth_wallace_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .a_i (w_a_sel),
        .b_i (w_b_sel),
        .p_o (w_prod)
    );

    // Output-register occupancy: a transfer always fills, a drain empties
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (w_xfer) state_d = FULL;
            FULL:    if (!w_xfer && rsp_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // State and result registers; result is kept (not cleared) on drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= EMPTY;
            rsp_product_q <= '0;
            rsp_id_q      <= '0;
        end else begin
            state_q <= state_d;
            if (w_xfer) begin
                rsp_product_q <= w_prod;
                rsp_id_q      <= w_grant_idx;
            end
        end
    end

    assign rsp_valid   = (state_q == FULL);
    assign rsp_product = rsp_product_q;
    assign rsp_id      = rsp_id_q;
endmodule

`default_nettype wire

// File: tb/tb_mul_arb.sv
// ============================================================================
//  Module      : tb_mul_arb
//  Description : Self-checking bench for mul_arb (WIDTH=8, NREQ=4) with a
//                queue-based reference model for randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_arb;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [2*WIDTH-1:0]    rsp_product;
    logic [IDW-1:0]        rsp_id;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2*WIDTH-1:0] p;
        logic [IDW-1:0]     id;
    } exp_t;

    mul_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req_valid = '0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        #2;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        #3;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_product !== 16'h0) begin failures++; $display("FAIL reset_product got=%h exp=0000", rsp_product); end
        checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        req_valid = '0;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        req_valid = 4'b0010;
        req_a[1*WIDTH +: WIDTH] = 8'hFD;   // -3
        req_b[1*WIDTH +: WIDTH] = 8'd7;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL basic_ready got=%b exp=0010", req_ready); end
        tick;
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_product !== 16'hFFEB) begin failures++; $display("FAIL basic_product got=%h exp=ffeb", rsp_product); end
        checks++; if (rsp_id !== 2'd1) begin failures++; $display("FAIL basic_id got=%0d exp=1", rsp_id); end
        tick;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_product !== 16'hFFEB) begin failures++; $display("FAIL drain_keep got=%h exp=ffeb", rsp_product); end
    endtask

    task automatic test_round_robin;
        do_reset;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = 8'(i + 1);
            req_b[i*WIDTH +: WIDTH] = 8'd10;
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            int e;
`ifdef MUL_ARB_FIXED_PRIO_EN
            e = 0;
`else
            e = c % NREQ;
`endif
            #1;
            checks++; if (req_ready !== 4'(1 << e)) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, req_ready, 4'(1 << e)); end
            tick;
            checks++; if (rsp_id !== 2'(e) || rsp_product !== 16'((e + 1) * 10))
                begin failures++; $display("FAIL rr_result cyc=%0d got id=%0d p=%0d exp id=%0d p=%0d", c, rsp_id, rsp_product, e, (e + 1) * 10); end
        end
    endtask

    task automatic test_hold;
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL hold_ready cyc=%0d got=%b exp=0000", c, req_ready); end
            tick;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== 16'd10)
                begin failures++; $display("FAIL hold_stable cyc=%0d got v=%b id=%0d p=%0d exp v=1 id=0 p=10", c, rsp_valid, rsp_id, rsp_product); end
        end
        req_valid = 4'b0100;
        req_a[2*WIDTH +: WIDTH] = 8'd5;
        req_b[2*WIDTH +: WIDTH] = 8'hFA;   // -6
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL reload_ready got=%b exp=0100", req_ready); end
        tick;
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_product !== 16'hFFE2)
            begin failures++; $display("FAIL reload_result got v=%b id=%0d p=%h exp v=1 id=2 p=ffe2", rsp_valid, rsp_id, rsp_product); end
        tick;
    endtask

    task automatic test_corners;
        logic [7:0]  ta [6] = '{8'h80, 8'h01, 8'h00, 8'h7F, 8'h80, 8'h7F};
        logic [7:0]  tb [6] = '{8'h80, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'h7F};
        logic [15:0] tp [6] = '{16'd16384, 16'hFFFF, 16'h0000, 16'hC080, 16'hC080, 16'd16129};
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid = 4'b0001;
            req_a[0 +: WIDTH] = ta[i];
            req_b[0 +: WIDTH] = tb[i];
            tick;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== tp[i])
                begin failures++; $display("FAIL corner_%0d got v=%b id=%0d p=%h exp v=1 id=0 p=%h", i, rsp_valid, rsp_id, rsp_product, tp[i]); end
        end
        req_valid = '0;
        tick;
    endtask

    task automatic test_async_reset;
        req_valid = 4'b0010;
        req_a[1*WIDTH +: WIDTH] = 8'd9;
        req_b[1*WIDTH +: WIDTH] = 8'd9;
        rsp_ready = 1'b0;
        tick;
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b exp=1", rsp_valid); end
        #3;
        rst = 1'b1;
        req_valid = 4'b1000;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_product !== 16'h0 || rsp_id !== 2'd0 || req_ready !== 4'b0)
            begin failures++; $display("FAIL arst_now got v=%b p=%h id=%0d rdy=%b exp v=0 p=0000 id=0 rdy=0000", rsp_valid, rsp_product, rsp_id, req_ready); end
        #1;
        rst = 1'b0;
        req_a[3*WIDTH +: WIDTH] = 8'hF9;   // -7
        req_b[3*WIDTH +: WIDTH] = 8'd3;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL arst_grant got=%b exp=1000", req_ready); end
        tick;
        req_valid = '0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_product !== 16'hFFEB)
            begin failures++; $display("FAIL arst_result got v=%b id=%0d p=%h exp v=1 id=3 p=ffeb", rsp_valid, rsp_id, rsp_product); end
        rsp_ready = 1'b1;
        tick;
    endtask

    task automatic test_random;
        exp_t q[$];
        int   mptr;
        do_reset;
        mptr = 0;
        for (int c = 0; c < 1000; c++) begin
            int           g;
            logic         full;
            logic         acc;
            logic [3:0]   exp_rdy;
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                req_a[i*WIDTH +: WIDTH] = 8'($urandom);
                req_b[i*WIDTH +: WIDTH] = 8'($urandom);
            end
            #1;
            full = (q.size() > 0);
            checks++; if (rsp_valid !== full) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, rsp_valid, full); end
            if (full) begin
                checks++; if (rsp_product !== q[0].p || rsp_id !== q[0].id)
                    begin failures++; $display("FAIL rnd_result cyc=%0d got p=%h id=%0d exp p=%h id=%0d", c, rsp_product, rsp_id, q[0].p, q[0].id); end
            end
            acc = !full || rsp_ready;
            g = -1;
            if (acc) begin
                for (int k = 0; k < NREQ; k++) begin
`ifdef MUL_ARB_FIXED_PRIO_EN
                    int n = k;
`else
                    int n = (mptr + k) % NREQ;
`endif
                    if (g < 0 && req_valid[n]) g = n;
                end
            end
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
            if (full && rsp_ready) void'(q.pop_front());
            if (g >= 0) begin
                logic signed [7:0]  ea;
                logic signed [7:0]  eb;
                logic signed [15:0] ep;
                exp_t               e;
                ea = req_a[g*WIDTH +: WIDTH];
                eb = req_b[g*WIDTH +: WIDTH];
                ep = ea * eb;
                e.p  = ep;
                e.id = 2'(g);
                q.push_back(e);
                mptr = (g + 1) % NREQ;
            end
            tick;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rnd_drain got=%b exp=0", rsp_valid); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_round_robin;
        test_hold;
        test_corners;
        test_async_reset;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
